// File: rtl/div_unit.sv
// Multi-cycle 32-bit RISC-V M divider (DIV/DIVU/REM/REMU) using restoring shift-subtract.
// Optional macro DIV_FAST_SPECIAL_EN finishes divide-by-zero and signed overflow in one cycle.
module div_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
   input  logic [1:0]       op_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   output logic             busy_o,
   output logic             done_o,
   output logic [WIDTH-1:0] r_o,
   output logic             zero_o
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

   state_t           state_q;
   logic [5:0]       cnt_q;
   logic             isRem_q, negQ_q, negR_q, divZero_q;
   logic [WIDTH-1:0] a_q, bMag_q, rem_q, quo_q, r_q;
   logic             busy_q, done_q, zero_q;

   logic             isSigned, aNeg, bNeg;
   logic [WIDTH-1:0] aMag, bMag;
   logic [WIDTH:0]   remShift;
   logic [WIDTH-1:0] diffLo, stepRem_d, stepQuo_d, quoFix, remFix, result_d;
   logic             ge;

   always_comb begin
      isSigned = ~op_i[0];
      aNeg     = isSigned & a_i[WIDTH-1];
      bNeg     = isSigned & b_i[WIDTH-1];
      // -(2^31) negates back to 0x80000000, which is the correct unsigned magnitude
      aMag     = aNeg ? (~a_i + ONE) : a_i;
      bMag     = bNeg ? (~b_i + ONE) : b_i;

      remShift  = {rem_q, quo_q[WIDTH-1]};
      diffLo    = remShift[WIDTH-1:0] - bMag_q;
      ge        = remShift[WIDTH] | (remShift[WIDTH-1:0] >= bMag_q);
      stepRem_d = ge ? diffLo : remShift[WIDTH-1:0];
      stepQuo_d = {quo_q[WIDTH-2:0], ge};

      quoFix = negQ_q ? (~quo_q + ONE) : quo_q;
      remFix = negR_q ? (~rem_q + ONE) : rem_q;
      if (divZero_q)
         result_d = isRem_q ? a_q : '1;
      else
         result_d = isRem_q ? remFix : quoFix;
   end

`ifdef DIV_FAST_SPECIAL_EN
   logic             fastDivZero, fastOvf, fastHit;
   logic [WIDTH-1:0] fastRes;

   always_comb begin
      fastDivZero = (b_i == '0);
      fastOvf     = isSigned && (a_i == {1'b1, {(WIDTH-1){1'b0}}}) && (b_i == '1);
      fastHit     = fastDivZero | fastOvf;
      if (fastDivZero)
         fastRes = op_i[1] ? a_i : '1;
      else
         fastRes = op_i[1] ? '0 : {1'b1, {(WIDTH-1){1'b0}}};
   end
`endif

   // DONE behaves like IDLE for start acceptance so back-to-back requests are taken
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         isRem_q   <= 1'b0;
         negQ_q    <= 1'b0;
         negR_q    <= 1'b0;
         divZero_q <= 1'b0;
         a_q       <= '0;
         bMag_q    <= '0;
         rem_q     <= '0;
         quo_q     <= '0;
         r_q       <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         zero_q    <= 1'b1;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            RUN: begin
               if (cnt_q == 6'd32) begin
                  r_q     <= result_d;
                  zero_q  <= (result_d == '0);
                  done_q  <= 1'b1;
                  busy_q  <= 1'b0;
                  state_q <= DONE;
               end else begin
                  rem_q <= stepRem_d;
                  quo_q <= stepQuo_d;
                  cnt_q <= cnt_q + 6'd1;
               end
            end
            default: begin
               if (start_i) begin
                  isRem_q   <= op_i[1];
                  negQ_q    <= aNeg ^ bNeg;
                  negR_q    <= aNeg;
                  divZero_q <= (b_i == '0);
                  a_q       <= a_i;
                  bMag_q    <= bMag;
                  rem_q     <= '0;
                  quo_q     <= aMag;
                  cnt_q     <= '0;
`ifdef DIV_FAST_SPECIAL_EN
                  if (fastHit) begin
                     r_q     <= fastRes;
                     zero_q  <= (fastRes == '0);
                     done_q  <= 1'b1;
                     state_q <= DONE;
                  end else begin
                     busy_q  <= 1'b1;
                     state_q <= RUN;
                  end
`else
                  busy_q  <= 1'b1;
                  state_q <= RUN;
`endif
               end else begin
                  state_q <= IDLE;
               end
            end
         endcase
      end
   end

   assign busy_o = busy_q;
   assign done_o = done_q;
   assign r_o    = r_q;
   assign zero_o = zero_q;

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: expected results queued at start, compared when done_o pulses.
// Latency expectations follow DIV_FAST_SPECIAL_EN when the bench is built with it.
module tb_div_unit;

   logic        clk_i = 1'b0;
   logic        rst_i, start_i;
   logic [1:0]  op_i;
   logic [31:0] a_i, b_i;
   logic        busy_o, done_o, zero_o;
   logic [31:0] r_o;

   typedef struct {
      logic [31:0] r;
      logic        z;
      int          lat;
   } exp_t;

   exp_t sb[$];
   int   vectors = 0;
   int   miscompares = 0;

   div_unit #(.WIDTH(32)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .op_i(op_i),
      .a_i(a_i), .b_i(b_i), .busy_o(busy_o), .done_o(done_o),
      .r_o(r_o), .zero_o(zero_o)
   );

   always #5 clk_i = ~clk_i;

   function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      logic ovf;
      ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
      case (op)
         2'b00:   model = (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'($signed(a) / $signed(b));
         2'b01:   model = (b == 0) ? 32'hFFFF_FFFF : a / b;
         2'b10:   model = (b == 0) ? a : ovf ? 32'h0 : 32'($signed(a) % $signed(b));
         default: model = (b == 0) ? a : a % b;
      endcase
   endfunction

   // Edges after the sampling edge until done_o is seen
   function automatic int expLat(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
`ifdef DIV_FAST_SPECIAL_EN
      if (b == 0 || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))
         return 0;
`endif
      return 33;
   endfunction

   // Drives one request starting at posedge+1 and returns once done_o is seen (or the bound expires)
   task automatic runOp(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output logic [31:0] rOut, output logic zOut,
                        output bit busyOk, output bit rStable);
      exp_t e;
      logic [31:0] rPrev;
      e.r = model(op, a, b);
      e.z = (e.r == 0);
      e.lat = expLat(op, a, b);
      sb.push_back(e);
      rPrev = r_o;
      start_i = 1'b1; op_i = op; a_i = a; b_i = b;
      @(posedge clk_i); #1;
      start_i = 1'b0;
      lat = 0; busyOk = 1'b1; rStable = 1'b1;
      while (!done_o && lat < 100) begin
         if (busy_o !== 1'b1) busyOk = 1'b0;
         if (r_o !== rPrev) rStable = 1'b0;
         @(posedge clk_i); #1;
         lat++;
      end
      rOut = r_o;
      zOut = zero_o;
   endtask

   task automatic test_reset;
      rst_i = 1'b1; start_i = 1'b0; op_i = 2'b00; a_i = '0; b_i = '0;
      repeat (3) @(posedge clk_i);
      #1;
      vectors++; if (busy_o !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_busy got %b exp 0", busy_o); end
      vectors++; if (done_o !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_done got %b exp 0", done_o); end
      vectors++; if (r_o !== 32'h0) begin miscompares++; $display("[TB] FAIL reset_r got %h exp 00000000", r_o); end
      vectors++; if (zero_o !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_zero got %b exp 1", zero_o); end
      rst_i = 1'b0;
      @(posedge clk_i); #1;
   endtask

   task automatic test_divu;
      int lat; logic [31:0] r; logic z; bit bOk, rOk; exp_t e;
      runOp(2'b01, 32'd100, 32'd7, lat, r, z, bOk, rOk);
      e = sb.pop_front();
      vectors++; if (r !== e.r) begin miscompares++; $display("[TB] FAIL divu_r got %h exp %h", r, e.r); end
      vectors++; if (lat !== e.lat) begin miscompares++; $display("[TB] FAIL divu_lat got %0d exp %0d", lat, e.lat); end
      vectors++; if (bOk !== 1'b1) begin miscompares++; $display("[TB] FAIL divu_busy got %b exp 1", bOk); end
      vectors++; if (rOk !== 1'b1) begin miscompares++; $display("[TB] FAIL divu_r_hold got %b exp 1", rOk); end
      vectors++; if (busy_o !== 1'b0) begin miscompares++; $display("[TB] FAIL divu_busy_done got %b exp 0", busy_o); end
      @(posedge clk_i); #1;
      vectors++; if (done_o !== 1'b0) begin miscompares++; $display("[TB] FAIL divu_pulse got %b exp 0", done_o); end
      vectors++; if (r_o !== e.r) begin miscompares++; $display("[TB] FAIL divu_r_stable got %h exp %h", r_o, e.r); end
   endtask

   task automatic test_signed;
      logic [1:0]  ops[4] = '{2'b10, 2'b00, 2'b00, 2'b10};
      logic [31:0] as[4]  = '{32'hFFFF_FF9C, 32'hFFFF_FF9C, 32'd100, 32'hFFFF_FF9C};
      logic [31:0] bs[4]  = '{32'd7, 32'd7, 32'hFFFF_FFF9, 32'hFFFF_FFF9};
      for (int i = 0; i < 4; i++) begin
         int lat; logic [31:0] r; logic z; bit bOk, rOk; exp_t e;
         runOp(ops[i], as[i], bs[i], lat, r, z, bOk, rOk);
         e = sb.pop_front();
         vectors++; if (r !== e.r) begin miscompares++; $display("[TB] FAIL signed%0d_r got %h exp %h", i, r, e.r); end
         vectors++; if (lat !== e.lat) begin miscompares++; $display("[TB] FAIL signed%0d_lat got %0d exp %0d", i, lat, e.lat); end
      end
   endtask

   task automatic test_special;
      logic [1:0]  ops[6] = '{2'b00, 2'b10, 2'b01, 2'b11, 2'b00, 2'b10};
      logic [31:0] as[6]  = '{32'h8000_0000, 32'h8000_0000, 32'd5, 32'd5, 32'hFFFF_FFFB, 32'hFFFF_FFFB};
      logic [31:0] bs[6]  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0, 32'd0, 32'd0};
      for (int i = 0; i < 6; i++) begin
         int lat; logic [31:0] r; logic z; bit bOk, rOk; exp_t e;
         runOp(ops[i], as[i], bs[i], lat, r, z, bOk, rOk);
         e = sb.pop_front();
         vectors++; if (r !== e.r) begin miscompares++; $display("[TB] FAIL special%0d_r got %h exp %h", i, r, e.r); end
         vectors++; if (z !== e.z) begin miscompares++; $display("[TB] FAIL special%0d_zero got %b exp %b", i, z, e.z); end
         vectors++; if (lat !== e.lat) begin miscompares++; $display("[TB] FAIL special%0d_lat got %0d exp %0d", i, lat, e.lat); end
         @(posedge clk_i); #1;
         vectors++; if (done_o !== 1'b0) begin miscompares++; $display("[TB] FAIL special%0d_pulse got %b exp 0", i, done_o); end
      end
   endtask

   task automatic test_random;
      for (int i = 0; i < 8; i++) begin
         int lat; logic [31:0] r; logic z; bit bOk, rOk; exp_t e;
         logic [31:0] a, b;
         a = $urandom;
         b = (i < 4) ? ($urandom & 32'h0000_FFFF) : $urandom;
         if (b == 0) b = 32'd3;
         runOp(2'(i), a, b, lat, r, z, bOk, rOk);
         e = sb.pop_front();
         vectors++; if (r !== e.r) begin miscompares++; $display("[TB] FAIL rand%0d_r got %h exp %h (a=%h b=%h)", i, r, e.r, a, b); end
         vectors++; if (z !== e.z) begin miscompares++; $display("[TB] FAIL rand%0d_zero got %b exp %b", i, z, e.z); end
      end
   endtask

   task automatic test_abort;
      bit sawDone;
      int lat;
      exp_t e;
      start_i = 1'b1; op_i = 2'b01; a_i = 32'd100; b_i = 32'd7;
      @(posedge clk_i); #1;
      start_i = 1'b0;
      repeat (10) @(posedge clk_i);
      #1;
      rst_i = 1'b1;
      @(posedge clk_i); #1;
      rst_i = 1'b0;
      vectors++; if (busy_o !== 1'b0) begin miscompares++; $display("[TB] FAIL abort_busy got %b exp 0", busy_o); end
      vectors++; if (r_o !== 32'h0) begin miscompares++; $display("[TB] FAIL abort_r got %h exp 00000000", r_o); end
      vectors++; if (zero_o !== 1'b1) begin miscompares++; $display("[TB] FAIL abort_zero got %b exp 1", zero_o); end
      sawDone = 1'b0;
      repeat (40) begin
         @(posedge clk_i); #1;
         if (done_o === 1'b1 || r_o !== 32'h0) sawDone = 1'b1;
      end
      vectors++; if (sawDone !== 1'b0) begin miscompares++; $display("[TB] FAIL abort_no_done got %b exp 0", sawDone); end

      // New operation while extra starts with other operands are toggled during RUN
      e.r = model(2'b01, 32'd9, 32'd2); e.z = (e.r == 0); e.lat = 33;
      sb.push_back(e);
      start_i = 1'b1; op_i = 2'b01; a_i = 32'd9; b_i = 32'd2;
      @(posedge clk_i); #1;
      lat = 0;
      for (int k = 0; k < 10; k++) begin
         start_i = ~start_i; op_i = 2'b10; a_i = 32'd1; b_i = 32'd1;
         @(posedge clk_i); #1;
         lat++;
      end
      start_i = 1'b0;
      while (!done_o && lat < 100) begin
         @(posedge clk_i); #1;
         lat++;
      end
      e = sb.pop_front();
      vectors++; if (r_o !== e.r) begin miscompares++; $display("[TB] FAIL ignore_r got %h exp %h", r_o, e.r); end
      vectors++; if (lat !== e.lat) begin miscompares++; $display("[TB] FAIL ignore_lat got %0d exp %0d", lat, e.lat); end
      @(posedge clk_i); #1;
      vectors++; if (done_o !== 1'b0) begin miscompares++; $display("[TB] FAIL ignore_pulse got %b exp 0", done_o); end
   endtask

   task automatic test_back_to_back;
      int lat; logic [31:0] r; logic z; bit bOk, rOk; exp_t e;
      runOp(2'b01, 32'd9, 32'd3, lat, r, z, bOk, rOk);
      e = sb.pop_front();
      vectors++; if (r !== e.r) begin miscompares++; $display("[TB] FAIL b2b_first_r got %h exp %h", r, e.r); end
      // Second start is driven in the done_o cycle of the first
      runOp(2'b11, 32'd9, 32'd4, lat, r, z, bOk, rOk);
      e = sb.pop_front();
      vectors++; if (r !== e.r) begin miscompares++; $display("[TB] FAIL b2b_second_r got %h exp %h", r, e.r); end
      vectors++; if (lat !== e.lat) begin miscompares++; $display("[TB] FAIL b2b_second_lat got %0d exp %0d", lat, e.lat); end
      vectors++; if (bOk !== 1'b1) begin miscompares++; $display("[TB] FAIL b2b_busy got %b exp 1", bOk); end
      @(posedge clk_i); #1;
      vectors++; if (done_o !== 1'b0) begin miscompares++; $display("[TB] FAIL b2b_pulse got %b exp 0", done_o); end
   endtask

   initial begin
      test_reset();
      test_divu();
      test_signed();
      test_special();
      test_random();
      test_abort();
      test_back_to_back();
      vectors++;
      if (sb.size() !== 0) begin
         miscompares++;
         $display("[TB] FAIL scoreboard_empty got %0d exp 0", sb.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
